// File: rtl/bit_sampler_deser.sv
// Mid-bit sampler and sync-word deserializer for the recovered NRZ line (clk domain, 300 MHz).
// Optional: define BIT_SAMPLER_MAJORITY_EN to vote 2-of-3 samples around mid-bit (decision one clk later).
module bit_sampler_deser #(
  parameter int                  CLK_LEN    = 16,
  parameter int                  WORD_LEN   = 8,
  parameter logic [WORD_LEN-1:0] SYNC_WORD  = 8'hD5,
  parameter int                  MAX_RUN    = 16,
  parameter int                  MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                signal_in,
  input  logic [CLK_LEN-1:0]  bit_period,
  input  logic                data_ready,
  output logic [WORD_LEN-1:0] data_out,
  output logic                data_valid,
  output logic                locked,
  output logic                bit_strobe,
  output logic                overrun
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam int CNT_W = $clog2(WORD_LEN + 1);

  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

  state_t              state;
  logic                sync1, sync2, sync3;
  logic                line_edge;
  logic                period_ok;
  logic [CLK_LEN-1:0]  phase;
  logic [CLK_LEN-1:0]  mid;
  logic                sample_now;
  logic                sample_bit;
  logic                bit_val;
  logic [RUN_W-1:0]    run_cnt;
  logic                run_hit;
  logic [WORD_LEN-1:0] shreg;
  logic [WORD_LEN-1:0] shreg_next;
  logic [CNT_W-1:0]    bit_cnt;

  assign line_edge  = sync2 ^ sync3;
  assign period_ok  = bit_period >= CLK_LEN'(MIN_PERIOD);
  assign mid        = bit_period >> 1;
  assign shreg_next = {shreg[WORD_LEN-2:0], bit_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= '0;
    else if (!period_ok || line_edge)
      phase <= '0;
    else if (phase == bit_period - CLK_LEN'(1))
      phase <= '0;
    else
      phase <= phase + CLK_LEN'(1);
  end

`ifdef BIT_SAMPLER_MAJORITY_EN
  logic s_early, s_mid;

  // The window mid-1..mid+1 is contiguous unless an edge reloads the counter, which aborts the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b0;
      s_mid   <= 1'b0;
    end else if (period_ok && !line_edge) begin
      if (phase == mid - CLK_LEN'(1)) s_early <= sync3;
      if (phase == mid)               s_mid   <= sync3;
    end
  end

  assign sample_now = period_ok && !line_edge && (phase == mid + CLK_LEN'(1));
  assign sample_bit = (s_early & s_mid) | (s_early & sync3) | (s_mid & sync3);
`else
  assign sample_now = period_ok && !line_edge && (phase == mid);
  assign sample_bit = sync3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_strobe <= 1'b0;
      bit_val    <= 1'b0;
    end else begin
      bit_strobe <= sample_now;
      if (sample_now) bit_val <= sample_bit;
    end
  end

  assign run_hit = bit_strobe && !line_edge &&
                   (run_cnt >= RUN_W'(MAX_RUN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      run_cnt <= '0;
    else if (line_edge)
      run_cnt <= '0;
    else if (bit_strobe && run_cnt != RUN_W'(MAX_RUN))
      run_cnt <= run_cnt + RUN_W'(1);
  end

  // The bit decided on the strobe cycle is acted on at its end, so data_valid rises one clk after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      locked     <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      if (!period_ok) begin
        state  <= HUNT;
        locked <= 1'b0;
      end else if (bit_strobe) begin
        shreg <= shreg_next;
        if (run_hit) begin
          state   <= HUNT;
          locked  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          case (state)
            HUNT: begin
              if (shreg_next == SYNC_WORD) begin
                state   <= DATA;
                locked  <= 1'b1;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              if (bit_cnt == CNT_W'(WORD_LEN - 1)) begin
                bit_cnt <= '0;
                if (!data_valid || data_ready) begin
                  data_out   <= shreg_next;
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_sampler_deser.sv
// Directed bench for bit_sampler_deser: lock, handshake/overrun, loss of frame, period limits, jitter, reset.
module tb_bit_sampler_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        signal_in;
  logic [15:0] bit_period;
  logic        data_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        locked;
  logic        bit_strobe;
  logic        overrun;

  bit_sampler_deser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .signal_in  (signal_in),
    .bit_period (bit_period),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .bit_strobe (bit_strobe),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Line change -> strobe visible: 3 clk sync/edge + 15 clk to mid + 1 clk register (+1 with majority).
`ifdef BIT_SAMPLER_MAJORITY_EN
  localparam int EXP_LAT = 20;
`else
  localparam int EXP_LAT = 19;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         stb_cnt = 0;
  int         ovr_cnt = 0;
  int         dv_rises = 0;
  int         dv_lat = 0;
  int         last_stb = 0;
  logic       dv_q = 1'b0;
  logic [7:0] words[$];

  int bit_stb;
  int bit_lat;
  int b_stb, b_ovr, b_dv, b_w, k;
  int jit[16] = '{3, -3, 2, -2, 1, -1, 0, 3, -3, 3, -3, 2, -2, 1, -1, 0};
  logic [15:0] s5 = 16'hD555;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bit_strobe) begin
      stb_cnt  = stb_cnt + 1;
      last_stb = cyc;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (data_valid && data_ready) words.push_back(data_out);
    if (data_valid && !dv_q) begin
      dv_rises = dv_rises + 1;
      dv_lat   = cyc - last_stb;
    end
    dv_q = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int len);
    int t0;
    signal_in = b;
    t0 = cyc;
    bit_stb = 0;
    bit_lat = -1;
    repeat (len) begin
      @(negedge clk);
      if (bit_strobe) begin
        bit_stb++;
        bit_lat = cyc - t0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int len);
    for (int i = 7; i >= 0; i--) send_bit(b[i], len);
  endtask

  task automatic do_reset(input logic [15:0] bp, input logic rdy);
    rst_n      = 1'b0;
    signal_in  = 1'b0;
    bit_period = bp;
    data_ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    signal_in  = 1'b0;
    bit_period = 16'd30;
    data_ready = 1'b1;
    #1;
    chk("rst_valid",  data_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dout",   data_out, 0);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_ovr",    overrun, 0);

    // Lock and two back-to-back words with the sink always ready.
    do_reset(16'd30, 1'b1);
    b_w = words.size();
    send_bit(1'b0, 60);
    chk("t1_prelock", locked, 0);
    send_byte(8'hD5, 30);
    chk("t1_locked", locked, 1);
    send_byte(8'h3C, 30);
    chk("t1_nw1", words.size() - b_w, 1);
    chk("t1_w0", words[b_w], 8'h3C);
    chk("t1_lat0", dv_lat, 1);
    send_byte(8'hA1, 30);
    chk("t1_nw2", words.size() - b_w, 2);
    chk("t1_w1", words[b_w+1], 8'hA1);
    chk("t1_lat1", dv_lat, 1);

    // Sink stalled: second data word is dropped with one overrun pulse.
    do_reset(16'd30, 1'b0);
    b_ovr = ovr_cnt;
    b_w   = words.size();
    send_bit(1'b0, 60);
    send_byte(8'hD5, 30);
    send_byte(8'h3C, 30);
    chk("t2_valid1", data_valid, 1);
    chk("t2_dout1", data_out, 8'h3C);
    chk("t2_noovr", ovr_cnt - b_ovr, 0);
    send_byte(8'hA1, 30);
    chk("t2_ovr", ovr_cnt - b_ovr, 1);
    chk("t2_dout2", data_out, 8'h3C);
    chk("t2_valid2", data_valid, 1);
    data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t2_cleared", data_valid, 0);
    chk("t2_nw", words.size() - b_w, 1);
    chk("t2_w", words[b_w], 8'h3C);

    // Loss of frame: line held at 1 after the sync's final 1 bit.
    do_reset(16'd30, 1'b1);
    b_dv = dv_rises;
    b_w  = words.size();
    send_bit(1'b0, 60);
    send_byte(8'hD5, 30);
    chk("t3_locked", locked, 1);
    k = 0;
    for (int t = 0; t < 2000 && k < 15; t++) begin
      @(negedge clk);
      if (bit_strobe) k++;
    end
    chk("t3_strobes", k, 15);
    chk("t3_locked_at16", locked, 1);
    @(negedge clk);
    chk("t3_unlocked", locked, 0);
    chk("t3_word_ff", words[words.size()-1], 8'hFF);
    wait_cycles(600);
    chk("t3_one_word", dv_rises - b_dv, 1);
    chk("t3_still_hunt", locked, 0);

    // Invalid period: no strobes, no lock.
    do_reset(16'd3, 1'b1);
    b_stb = stb_cnt;
    send_bit(1'b0, 60);
    send_byte(8'hD5, 30);
    send_byte(8'h3C, 30);
    chk("t4_nostrobe", stb_cnt - b_stb, 0);
    chk("t4_nolock", locked, 0);

    // Smallest valid period locks.
    do_reset(16'd4, 1'b1);
    send_bit(1'b0, 20);
    send_byte(8'hD5, 5);
    wait_cycles(6);
    chk("t4_minper_lock", locked, 1);

    // Jittered line: one strobe per bit at a fixed delay from each line change.
    do_reset(16'd30, 1'b1);
    b_w = words.size();
    send_bit(1'b0, 60);
    for (int i = 0; i < 16; i++) begin
      send_bit(s5[15-i], 30 + jit[i]);
      chk($sformatf("t5_stb_%0d", i), bit_stb, 1);
      if (i >= 8) chk($sformatf("t5_lat_%0d", i), bit_lat, EXP_LAT);
    end
    chk("t5_locked", locked, 1);
    chk("t5_nw", words.size() - b_w, 1);
    chk("t5_w", words[words.size()-1], 8'h55);

    // Reset mid-word with a pending word, then re-hunt.
    do_reset(16'd30, 1'b0);
    send_bit(1'b0, 60);
    send_byte(8'hD5, 30);
    send_byte(8'h3C, 30);
    chk("t6_pending", data_valid, 1);
    send_bit(1'b1, 30);
    send_bit(1'b0, 30);
    send_bit(1'b1, 30);
    send_bit(1'b0, 30);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid",  data_valid, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_dout",   data_out, 0);
    chk("t6_rst_strobe", bit_strobe, 0);
    chk("t6_rst_ovr",    overrun, 0);
    wait_cycles(2);
    rst_n      = 1'b1;
    data_ready = 1'b1;
    b_dv = dv_rises;
    send_byte(8'hA1, 30);
    chk("t6_hunt", locked, 0);
    chk("t6_nodv", dv_rises - b_dv, 0);
    send_byte(8'hD5, 30);
    chk("t6_relock", locked, 1);
    send_byte(8'h3C, 30);
    chk("t6_dv", dv_rises - b_dv, 1);
    chk("t6_w", words[words.size()-1], 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
